// File: rtl/xfmr_token_sequencer_if.sv
// Token-sequencer bus: input token stream, transformer-block start/result strobes,
// and the result output stream.
interface xfmr_token_sequencer_if #(
    parameter int unsigned D       = 2,
    parameter int unsigned DW      = 8,
    parameter int unsigned SEQ_LEN = 2
);
    localparam int unsigned IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    logic                        in_valid;
    logic                        in_ready;
    logic signed [D-1:0][DW-1:0] in_vec;
    logic                        in_last;

    logic                        blk_start;
    logic signed [D-1:0][DW-1:0] blk_x;
    logic                        blk_out_valid;
    logic signed [D-1:0][DW-1:0] blk_y;

    logic                        out_valid;
    logic                        out_ready;
    logic signed [D-1:0][DW-1:0] out_vec;
    logic                        out_last;

    logic [IDX_W-1:0]            tok_idx;
    logic                        busy;
    logic                        err_tmo;

    // Sequencer side
    modport master (
        input  in_valid, in_vec, in_last, blk_out_valid, blk_y, out_ready,
        output in_ready, blk_start, blk_x, out_valid, out_vec, out_last,
               tok_idx, busy, err_tmo
    );

    // Environment side (token source, transformer block, result sink)
    modport slave (
        output in_valid, in_vec, in_last, blk_out_valid, blk_y, out_ready,
        input  in_ready, blk_start, blk_x, out_valid, out_vec, out_last,
               tok_idx, busy, err_tmo
    );
endinterface

// File: rtl/xfmr_token_sequencer.sv
// Buffers token vectors, issues them one at a time to the transformer block and
// returns results in order. Optional S_WAIT watchdog: define XFMR_SEQ_WATCHDOG_EN.
module xfmr_token_sequencer #(
    parameter int unsigned D          = 2,
    parameter int unsigned DW         = 8,
    parameter int unsigned SEQ_LEN    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TMO_W      = 8
) (
    input logic                      clk,
    input logic                      rst,
    xfmr_token_sequencer_if.master   bus
);
    localparam int unsigned VW    = D * DW;
    localparam int unsigned ENT_W = VW + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    typedef logic signed [D-1:0][DW-1:0] vec_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             in_ready_q, in_ready_d;
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0] head_c;
    logic             push_c, pop_c, empty_c;

    vec_t             blk_x_q, blk_x_d;
    logic             last_q, last_d;
    logic             blk_start_q, blk_start_d;
    logic             out_valid_q, out_valid_d;
    vec_t             out_vec_q, out_vec_d;
    logic             out_last_q, out_last_d;
    logic [IDX_W-1:0] tok_idx_q, tok_idx_d;
    logic             busy_q, busy_d;
`ifdef XFMR_SEQ_WATCHDOG_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_tmo_q, err_tmo_d;
`else
    localparam int unsigned unused_tmo_w = TMO_W;
`endif

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign head_c  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // FIFO pointers; in_ready is registered so a pop only frees the slot next cycle
    always_comb begin
        push_c   = bus.in_valid && in_ready_q;
        wr_ptr_d = push_c ? wr_ptr_q + CNT_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + CNT_W'(1) : rd_ptr_q;
        in_ready_d = !((wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                       (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]));
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.in_last, bus.in_vec};
    end

    // Issue FSM: one token in flight, result held until the sink accepts it
    always_comb begin
        state_d     = state_q;
        pop_c       = 1'b0;
        blk_x_d     = blk_x_q;
        last_d      = last_q;
        blk_start_d = 1'b0;
        out_valid_d = out_valid_q;
        out_vec_d   = out_vec_q;
        out_last_d  = out_last_q;
        tok_idx_d   = tok_idx_q;
`ifdef XFMR_SEQ_WATCHDOG_EN
        tmo_cnt_d   = tmo_cnt_q;
        err_tmo_d   = err_tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!empty_c && !out_valid_q) begin
                    pop_c       = 1'b1;
                    blk_x_d     = head_c[VW-1:0];
                    last_d      = head_c[VW];
                    blk_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef XFMR_SEQ_WATCHDOG_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (bus.blk_out_valid) begin
                    out_vec_d   = bus.blk_y;
                    out_last_d  = last_q;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
`ifdef XFMR_SEQ_WATCHDOG_EN
                else if (tmo_cnt_q == '1) begin
                    err_tmo_d   = 1'b1;
                    out_vec_d   = '0;
                    out_last_d  = last_q;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            S_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q || (tok_idx_q == IDX_W'(SEQ_LEN - 1)))
                        tok_idx_d = '0;
                    else
                        tok_idx_d = tok_idx_q + IDX_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b0;
            blk_x_q     <= '0;
            last_q      <= 1'b0;
            blk_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_last_q  <= 1'b0;
            tok_idx_q   <= '0;
            busy_q      <= 1'b0;
`ifdef XFMR_SEQ_WATCHDOG_EN
            tmo_cnt_q   <= '0;
            err_tmo_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            blk_x_q     <= blk_x_d;
            last_q      <= last_d;
            blk_start_q <= blk_start_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            out_last_q  <= out_last_d;
            tok_idx_q   <= tok_idx_d;
            busy_q      <= busy_d;
`ifdef XFMR_SEQ_WATCHDOG_EN
            tmo_cnt_q   <= tmo_cnt_d;
            err_tmo_q   <= err_tmo_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.blk_start = blk_start_q;
    assign bus.blk_x     = blk_x_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = out_vec_q;
    assign bus.out_last  = out_last_q;
    assign bus.tok_idx   = tok_idx_q;
    assign bus.busy      = busy_q;
`ifdef XFMR_SEQ_WATCHDOG_EN
    assign bus.err_tmo   = err_tmo_q;
`else
    assign bus.err_tmo   = 1'b0;
`endif
endmodule

// File: tb/tb_xfmr_token_sequencer.sv
// Directed bench for xfmr_token_sequencer with a behavioural transformer block
// and an in-order result scoreboard.
module tb_xfmr_token_sequencer;
    localparam int unsigned D          = 2;
    localparam int unsigned DW         = 8;
    localparam int unsigned SEQ_LEN    = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TMO_W      = 4;
    localparam int unsigned VW         = D * DW;
    localparam int unsigned IDX_W      = $clog2(SEQ_LEN);
    localparam int unsigned BLK_LAT    = 5;

    typedef logic signed [D-1:0][DW-1:0] vec_t;
    typedef struct packed { logic last; vec_t vec; } out_e_t;
    typedef struct packed { vec_t x; logic [IDX_W-1:0] idx; } in_e_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_starts = 0;

    out_e_t exp_q[$];
    in_e_t  xq[$];
    logic [IDX_W-1:0] exp_idx = '0;
    logic   exp_zero = 1'b0;
    logic   mdl_mute = 1'b0;
    logic   mdl_ov   = 1'b0;
    vec_t   mdl_y    = '0;
    logic   spur_ov  = 1'b0;
    vec_t   spur_y   = '0;
    vec_t   mdl_snap;

    xfmr_token_sequencer_if #(.D(D), .DW(DW), .SEQ_LEN(SEQ_LEN)) u_if ();

    xfmr_token_sequencer #(
        .D(D), .DW(DW), .SEQ_LEN(SEQ_LEN), .FIFO_DEPTH(FIFO_DEPTH), .TMO_W(TMO_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    assign u_if.blk_out_valid = mdl_ov | spur_ov;
    assign u_if.blk_y         = spur_ov ? spur_y : mdl_y;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int b);
        vec_t v;
        v[0] = DW'(a);
        v[1] = DW'(b);
        return v;
    endfunction

    // Behavioural block transfer function: lane0 + 4, lane1 + 3
    function automatic vec_t blk_f(input vec_t x);
        vec_t y;
        y[0] = x[0] + DW'(4);
        y[1] = x[1] + DW'(3);
        return y;
    endfunction

    task automatic record(input vec_t v, input logic last);
        in_e_t  ie;
        out_e_t oe;
        ie.x   = v;
        ie.idx = exp_idx;
        xq.push_back(ie);
        oe.last = last;
        oe.vec  = exp_zero ? vec_t'('0) : blk_f(v);
        exp_q.push_back(oe);
        if (last || (exp_idx == IDX_W'(SEQ_LEN - 1))) exp_idx = '0;
        else exp_idx = exp_idx + IDX_W'(1);
    endtask

    task automatic push(input vec_t v, input logic last);
        logic done = 1'b0;
        u_if.in_valid = 1'b1;
        u_if.in_vec   = v;
        u_if.in_last  = last;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (u_if.in_ready) begin
                record(v, last);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        u_if.in_valid = 1'b0;
        chk("push_accepted", VW'(done), VW'(1));
    endtask

    task automatic drain();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !u_if.busy) break;
        end
        chk("drain_empty", VW'(exp_q.size()), VW'(0));
    endtask

    // Transformer block model: checks issued token, responds after BLK_LAT cycles
    always begin
        @(negedge clk);
        if (rst && u_if.blk_start) begin
            logic aborted;
            in_e_t e;
            n_starts++;
            assert (xq.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_start: got start expected none");
            end
            if (xq.size() != 0) begin
                e = xq.pop_front();
                chk("blk_x_at_start", VW'(u_if.blk_x), VW'(e.x));
                chk("tok_idx_at_start", VW'(u_if.tok_idx), VW'(e.idx));
            end
            mdl_snap = u_if.blk_x;
            @(negedge clk);
            chk("blk_start_width", VW'(u_if.blk_start), VW'(0));
            if (!mdl_mute) begin
                aborted = 1'b0;
                for (int k = 0; k < int'(BLK_LAT) - 2; k++) begin
                    @(negedge clk);
                    if (!rst) aborted = 1'b1;
                end
                if (!aborted && rst) begin
                    chk("blk_x_held", VW'(u_if.blk_x), VW'(mdl_snap));
                    mdl_y  = blk_f(mdl_snap);
                    mdl_ov = 1'b1;
                    @(negedge clk);
                    mdl_ov = 1'b0;
                end
            end
        end
    end

    // Result scoreboard
    always @(negedge clk) begin
        if (rst && u_if.out_valid && u_if.out_ready) begin
            out_e_t e;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_result: got out_valid expected none");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                chk("out_vec", VW'(u_if.out_vec), VW'(e.vec));
                chk("out_last", VW'(u_if.out_last), VW'(e.last));
                n_tests--;
            end
        end
    end

    initial begin
        vec_t toks[6];
        logic lasts[6];
        int   n_acc;
        int   s0;

        rst = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_vec    = '0;
        u_if.in_last   = 1'b0;
        u_if.out_ready = 1'b0;

        // Reset idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  VW'(u_if.in_ready),  VW'(0));
        chk("rst_blk_start", VW'(u_if.blk_start), VW'(0));
        chk("rst_blk_x",     VW'(u_if.blk_x),     VW'(0));
        chk("rst_out_valid", VW'(u_if.out_valid), VW'(0));
        chk("rst_out_vec",   VW'(u_if.out_vec),   VW'(0));
        chk("rst_out_last",  VW'(u_if.out_last),  VW'(0));
        chk("rst_tok_idx",   VW'(u_if.tok_idx),   VW'(0));
        chk("rst_busy",      VW'(u_if.busy),      VW'(0));
        chk("rst_err_tmo",   VW'(u_if.err_tmo),   VW'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready",  VW'(u_if.in_ready),  VW'(1));
        chk("post_rst_busy",      VW'(u_if.busy),      VW'(0));
        chk("post_rst_blk_start", VW'(u_if.blk_start), VW'(0));

        // Single token: start pulses in the third cycle counting the push cycle
        @(posedge clk);
        #1 u_if.out_ready = 1'b1;
        push(mk(3, -5), 1'b1);
        @(negedge clk);
        chk("single_start_c1", VW'(u_if.blk_start), VW'(0));
        @(negedge clk);
        chk("single_start_c2", VW'(u_if.blk_start), VW'(1));
        chk("single_blk_x",    VW'(u_if.blk_x),     VW'(mk(3, -5)));
        @(negedge clk);
        chk("single_start_c3", VW'(u_if.blk_start), VW'(0));
        chk("single_busy",     VW'(u_if.busy),      VW'(1));
        drain();
        chk("single_tok_idx",  VW'(u_if.tok_idx),   VW'(0));

        // Backpressure: FIFO fills behind the in-flight token
        toks[0] = mk(1, 2);    lasts[0] = 1'b0;
        toks[1] = mk(-3, 4);   lasts[1] = 1'b1;
        toks[2] = mk(5, -6);   lasts[2] = 1'b0;
        toks[3] = mk(7, 8);    lasts[3] = 1'b1;
        toks[4] = mk(-9, 10);  lasts[4] = 1'b0;
        toks[5] = mk(11, -12); lasts[5] = 1'b1;
        s0 = n_starts;
        n_acc = 0;
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b0;
        u_if.in_valid  = 1'b1;
        u_if.in_vec    = toks[0];
        u_if.in_last   = lasts[0];
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (u_if.in_valid && u_if.in_ready) begin
                record(toks[n_acc], lasts[n_acc]);
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (n_acc < 6) begin
                u_if.in_vec  = toks[n_acc];
                u_if.in_last = lasts[n_acc];
            end else begin
                u_if.in_valid = 1'b0;
            end
        end
        // one token issued plus FIFO_DEPTH buffered
        chk("bp_accepted", VW'(n_acc), VW'(FIFO_DEPTH + 1));
        @(negedge clk);
        chk("bp_in_ready",   VW'(u_if.in_ready),  VW'(0));
        chk("bp_out_valid",  VW'(u_if.out_valid), VW'(1));
        chk("bp_one_start",  VW'(n_starts - s0),  VW'(1));
        repeat (3) @(negedge clk);
        chk("bp_out_vec_stable",  VW'(u_if.out_vec),  VW'(blk_f(toks[0])));
        chk("bp_out_last_stable", VW'(u_if.out_last), VW'(lasts[0]));
        @(posedge clk);
        #1 u_if.out_ready = 1'b1;
        for (int c = 0; c < 100 && n_acc < 6; c++) begin
            @(negedge clk);
            if (u_if.in_valid && u_if.in_ready) begin
                record(toks[n_acc], lasts[n_acc]);
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (n_acc >= 6) u_if.in_valid = 1'b0;
        end
        u_if.in_valid = 1'b0;
        chk("bp_all_accepted", VW'(n_acc), VW'(6));
        drain();
        chk("bp_starts", VW'(n_starts - s0), VW'(6));
        chk("bp_tok_idx", VW'(u_if.tok_idx), VW'(0));

        // Two sequences of SEQ_LEN tokens
        @(posedge clk);
        #1;
        push(mk(20, 21), 1'b0);
        push(mk(22, 23), 1'b1);
        push(mk(24, 25), 1'b0);
        push(mk(26, 27), 1'b1);
        drain();
        chk("seq_tok_idx_end", VW'(u_if.tok_idx), VW'(0));

        // Spurious block strobe while idle
        @(negedge clk);
        spur_y  = mk(1, 1);
        spur_ov = 1'b1;
        @(negedge clk);
        spur_ov = 1'b0;
        chk("spur_out_valid_a", VW'(u_if.out_valid), VW'(0));
        @(negedge clk);
        chk("spur_out_valid_b", VW'(u_if.out_valid), VW'(0));
        chk("spur_busy",        VW'(u_if.busy),      VW'(0));

        // Reset in the middle of S_WAIT
        @(posedge clk);
        #1;
        push(mk(10, 20), 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_busy_before", VW'(u_if.busy), VW'(1));
        #1 rst = 1'b0;
        #1;
        chk("mid_busy",      VW'(u_if.busy),      VW'(0));
        chk("mid_blk_x",     VW'(u_if.blk_x),     VW'(0));
        chk("mid_out_valid", VW'(u_if.out_valid), VW'(0));
        chk("mid_in_ready",  VW'(u_if.in_ready),  VW'(0));
        chk("mid_blk_start", VW'(u_if.blk_start), VW'(0));
        xq.delete();
        exp_q.delete();
        exp_idx = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_fifo_empty", VW'(u_if.busy),    VW'(0));
        chk("mid_tok_idx",    VW'(u_if.tok_idx), VW'(0));
        @(posedge clk);
        #1;
        push(mk(-100, 50), 1'b1);
        drain();
        chk("mid_after_tok_idx", VW'(u_if.tok_idx), VW'(0));

`ifdef XFMR_SEQ_WATCHDOG_EN
        // Block never answers: timeout emits a zero result and sets err_tmo
        mdl_mute = 1'b1;
        exp_zero = 1'b1;
        @(posedge clk);
        #1;
        push(mk(9, 9), 1'b1);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (u_if.err_tmo) break;
        end
        chk("wdg_err_tmo", VW'(u_if.err_tmo), VW'(1));
        drain();
        mdl_mute = 1'b0;
        exp_zero = 1'b0;
        @(negedge clk);
        spur_y  = mk(5, 5);
        spur_ov = 1'b1;
        @(negedge clk);
        spur_ov = 1'b0;
        @(negedge clk);
        chk("wdg_late_ignored", VW'(u_if.out_valid), VW'(0));
        chk("wdg_sticky",       VW'(u_if.err_tmo),   VW'(1));
`else
        chk("no_wdg_err_tmo", VW'(u_if.err_tmo), VW'(0));
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
